// File: rtl/func_rr_scheduler_pkg.sv
// rtl/func_rr_scheduler_pkg.sv - shared widths and state encoding for the round-robin FU scheduler
package func_rr_scheduler_pkg;

  localparam int FU_Y_W = 13;
  localparam int OP_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_ISSUE = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4,
    ST_TEST  = 3'd5
  } state_e;

endpackage

// File: rtl/func_rr_scheduler_rr_pick.sv
// rtl/func_rr_scheduler_rr_pick.sv - combinational round-robin pick: first set request at or above ptr, with wrap
module func_rr_scheduler_rr_pick
  import func_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/func_rr_scheduler.sv
// rtl/func_rr_scheduler.sv - time-shares one FU between NUM_REQ requesters with round-robin arbitration and self-test priority
module func_rr_scheduler
  import func_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ISSUE_TO = 64,
  parameter int RUN_TO   = 4096
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [OP_W*NUM_REQ-1:0] a_i,
  input  logic [OP_W*NUM_REQ-1:0] b_i,
  input  logic                    test_req_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [NUM_REQ-1:0]      done_o,
  output logic                    err_o,
  output logic [FU_Y_W-1:0]       y_o,
  output logic                    busy_o,
  output logic                    fu_start_o,
  output logic                    fu_test_o,
  output logic [OP_W-1:0]         fu_a_o,
  output logic [OP_W-1:0]         fu_b_o,
  input  logic                    fu_busy_i,
  input  logic [FU_Y_W-1:0]       fu_y_i
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int MAX_TO = (ISSUE_TO > RUN_TO) ? ISSUE_TO : RUN_TO;
  localparam int CNT_W  = $clog2(MAX_TO) + 1;
  localparam logic [CNT_W-1:0] ISSUE_LAST = CNT_W'(ISSUE_TO - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_TO - 1);

  state_e              state, state_nxt;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    win;
  logic [NUM_REQ-1:0]  win_oh;
  logic                test_op;
  logic                to_flag;
  logic [CNT_W-1:0]    cnt;
  logic                hit_to;
  logic                capture;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;

  func_rr_scheduler_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (req_i),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    state_nxt = state;
    hit_to    = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (test_req_i)      state_nxt = ST_TEST;
        else if (pick_valid) state_nxt = ST_GRANT;
      end
      ST_TEST:  state_nxt = ST_ISSUE;
      ST_GRANT: state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (fu_busy_i) begin
          state_nxt = ST_RUN;
        end else if (cnt == ISSUE_LAST) begin
          hit_to    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_RUN: begin
        if (!fu_busy_i) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end else if (cnt == RUN_LAST) begin
          hit_to    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      win     <= '0;
      win_oh  <= '0;
      test_op <= 1'b0;
      to_flag <= 1'b0;
      cnt     <= '0;
      y_o     <= '0;
      fu_a_o  <= '0;
      fu_b_o  <= '0;
    end else begin
      state <= state_nxt;
      // The counter only runs while waiting on the FU; any state change restarts it.
      if ((state == ST_ISSUE || state == ST_RUN) && state_nxt == state) cnt <= cnt + 1'b1;
      else                                                              cnt <= '0;
      if (hit_to)                 to_flag <= 1'b1;
      else if (state == ST_DONE)  to_flag <= 1'b0;
      if (state == ST_IDLE) test_op <= (state_nxt == ST_TEST);
      if (state == ST_IDLE && state_nxt == ST_GRANT) begin
        win    <= pick_idx;
        win_oh <= pick_onehot;
        fu_a_o <= a_i[pick_idx*OP_W +: OP_W];
        fu_b_o <= b_i[pick_idx*OP_W +: OP_W];
      end
      if (capture) y_o <= fu_y_i;
      if (state == ST_DONE && !test_op)
        ptr <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  assign busy_o     = (state != ST_IDLE);
  assign fu_start_o = (state == ST_ISSUE);
  assign fu_test_o  = (state == ST_TEST);
  assign err_o      = (state == ST_DONE) && to_flag;
  // Self-test passes reuse ISSUE/RUN/DONE but never show a grant or done to requesters.
  assign gnt_o  = (!test_op && (state == ST_GRANT || state == ST_ISSUE ||
                                state == ST_RUN   || state == ST_DONE)) ? win_oh : '0;
  assign done_o = (!test_op && state == ST_DONE) ? win_oh : '0;

endmodule

// File: tb/tb_func_rr_scheduler.sv
// tb/tb_func_rr_scheduler.sv - randomized self-checking bench for func_rr_scheduler with a transaction-level model
module tb_func_rr_scheduler;

  localparam int N   = 4;
  localparam int ITO = 8;
  localparam int RTO = 20;
  localparam logic [12:0] TEST_Y = 13'b0001001010001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_i = '0;
  logic [8*N-1:0] a_i = '0;
  logic [8*N-1:0] b_i = '0;
  logic          test_req_i = 1'b0;
  logic [N-1:0]  gnt_o, done_o;
  logic          err_o, busy_o, fu_start_o, fu_test_o;
  logic [12:0]   y_o;
  logic [7:0]    fu_a_o, fu_b_o;
  logic          fu_busy = 1'b0;
  logic [12:0]   fu_y = '0;

  func_rr_scheduler #(.NUM_REQ(N), .ISSUE_TO(ITO), .RUN_TO(RTO)) dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req_i), .a_i(a_i), .b_i(b_i),
    .test_req_i(test_req_i), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
    .y_o(y_o), .busy_o(busy_o), .fu_start_o(fu_start_o), .fu_test_o(fu_test_o),
    .fu_a_o(fu_a_o), .fu_b_o(fu_b_o), .fu_busy_i(fu_busy), .fu_y_i(fu_y)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] fu_func(input logic [7:0] a, input logic [7:0] b);
    return 13'((a * 31) + (b * 7));
  endfunction

  // FU behaviour: busy rises in the fu_d1-th start cycle, stays high for fu_r RUN cycles.
  int fu_d1 = 2;
  int fu_r  = 3;
  int fu_iss = 0;
  int fu_run = 0;
  logic fu_test_seen = 1'b0;

  always @(negedge clk) begin
    if (!busy_o) begin
      fu_iss = 0; fu_run = 0; fu_test_seen = 1'b0; fu_busy = 1'b0;
    end else if (fu_test_o) begin
      fu_test_seen = 1'b1;
    end else if (fu_start_o) begin
      fu_iss++;
      if (fu_iss == fu_d1) begin
        fu_busy = 1'b1;
        fu_y    = 13'($urandom);
      end
    end else if (fu_busy) begin
      fu_run++;
      if (fu_run > fu_r) begin
        fu_busy = 1'b0;
        fu_y    = fu_test_seen ? TEST_Y : fu_func(fu_a_o, fu_b_o);
      end
    end
  end

  // Transaction model: each accepted operation is a timeline of offsets 0..m_e.
  int          m_active = 0;
  int          m_o, m_l1, m_l2, m_e, m_win;
  int          m_ptr = 0;
  logic        m_test, m_to;
  logic [N-1:0] m_oh;
  logic [7:0]  m_a, m_b, m_fa = '0, m_fb = '0;
  logic [12:0] m_y = '0, m_ynew;
  int          served[$];
  int          err_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 0; m_ptr = 0; m_y = '0; m_fa = '0; m_fb = '0;
    end else begin
      if (done_o != '0)
        for (int i = 0; i < N; i++) if (done_o[i]) begin served.push_back(i); break; end
      if (err_o) err_cnt++;
      if (m_active != 0) begin
        m_o++;
        chk("busy", busy_o, 1);
        chk("gnt", gnt_o, m_test ? '0 : m_oh);
        chk("fu_test", fu_test_o, m_test && m_o == 0);
        chk("fu_start", fu_start_o, m_o >= 1 && m_o <= m_l1);
        chk("done", done_o, (m_o == m_e && !m_test) ? m_oh : '0);
        chk("err", err_o, m_o == m_e && m_to);
        chk("y", y_o, (m_o == m_e && !m_to) ? m_ynew : m_y);
        chk("fu_a", fu_a_o, m_fa);
        chk("fu_b", fu_b_o, m_fb);
        if (m_o == m_e) begin
          if (!m_to) m_y = m_ynew;
          if (!m_test) m_ptr = (m_win + 1) % N;
          m_active = 0;
        end
      end else begin
        chk("idle_busy", busy_o, 0);
        chk("idle_gnt", gnt_o, 0);
        chk("idle_done", done_o, 0);
        chk("idle_err", err_o, 0);
        chk("idle_start", fu_start_o | fu_test_o, 0);
        chk("idle_y", y_o, m_y);
        chk("idle_fu_a", fu_a_o, m_fa);
        chk("idle_fu_b", fu_b_o, m_fb);
        if (test_req_i || req_i != '0) begin
          m_active = 1;
          m_o      = -1;
          m_test   = test_req_i;
          m_win    = 0;
          if (!m_test) begin
            for (int i = 0; i < N; i++)
              if (req_i[(m_ptr + i) % N]) begin m_win = (m_ptr + i) % N; break; end
            m_a  = a_i[8*m_win +: 8];
            m_b  = b_i[8*m_win +: 8];
            m_fa = m_a;
            m_fb = m_b;
          end
          m_oh = N'(1) << m_win;
          if (fu_d1 <= ITO) begin
            m_l1 = fu_d1;
            m_to = (fu_r >= RTO);
            m_l2 = m_to ? RTO : fu_r + 1;
          end else begin
            m_l1 = ITO; m_l2 = 0; m_to = 1'b1;
          end
          m_e    = m_l1 + m_l2 + 1;
          m_ynew = m_test ? TEST_Y : fu_func(m_a, m_b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_served(input int n, input int budget);
    for (int i = 0; i < budget && served.size() < n; i++) tick();
    chk("served_count", served.size(), n);
  endtask

  function automatic int served_at(input int k);
    return (served.size() > k) ? served[k] : -1;
  endfunction

  task automatic wait_gnt(input int budget);
    for (int i = 0; i < budget && gnt_o == '0; i++) tick();
  endtask

  int e0;
  int exp_ord[$];

  initial begin
    tick(); tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_y", y_o, 0);
    chk("rst_fu_a", fu_a_o, 0);
    rst_n = 1'b1;
    tick();

    // single request
    a_i[7:0] = 8'd12; b_i[7:0] = 8'd60;
    req_i = 4'b0001;
    wait_served(1, 100);
    req_i = '0;
    chk("single_who", served_at(0), 0);
    chk("single_y", y_o, 13'd792);
    tick();
    chk("single_idle", busy_o, 0);

    // all four requesting, minimum-latency FU; pointer starts at 1 after serving 0
    served.delete();
    fu_d1 = 1; fu_r = 0;
    a_i = {8'd255, 8'd123, 8'd1, 8'd0};
    b_i = {8'd255, 8'd223, 8'd1, 8'd0};
    req_i = 4'b1111;
    wait_served(8, 200);
    req_i = '0;
    exp_ord = '{1, 2, 3, 0, 1, 2, 3, 0};
    foreach (exp_ord[k]) chk("rr_order", served_at(k), exp_ord[k]);

    // fairness between 0 and 2
    served.delete();
    fu_d1 = 2; fu_r = 2;
    req_i = 4'b0101;
    wait_served(6, 200);
    req_i = '0;
    exp_ord = '{2, 0, 2, 0, 2, 0};
    foreach (exp_ord[k]) chk("fair_order", served_at(k), exp_ord[k]);

    // self-test beats a simultaneous request
    tick();
    served.delete();
    fu_d1 = 3; fu_r = 2;
    test_req_i = 1'b1; req_i = 4'b0010;
    tick();
    test_req_i = 1'b0;
    chk("test_pulse", fu_test_o, 1);
    chk("test_gnt0", gnt_o, 0);
    wait_gnt(60);
    chk("test_then_gnt", gnt_o, 4'b0010);
    chk("test_y", y_o, TEST_Y);
    wait_served(1, 60);
    req_i = '0;
    chk("test_served", served_at(0), 1);

    // FU never becomes busy
    served.delete(); e0 = err_cnt;
    fu_d1 = ITO + 1;
    a_i[7:0] = 8'd12; b_i[7:0] = 8'd60;
    req_i = 4'b0001;
    wait_served(1, 100);
    req_i = '0;
    chk("issue_to_err", err_cnt - e0, 1);
    chk("issue_to_y", y_o, 13'd38);

    // boundary: busy in the last allowed issue cycle, done in the last allowed run cycle
    served.delete(); e0 = err_cnt;
    fu_d1 = ITO; fu_r = RTO - 1;
    req_i = 4'b0001;
    wait_served(1, 100);
    req_i = '0;
    chk("edge_no_err", err_cnt - e0, 0);
    chk("edge_y", y_o, 13'd792);

    // FU busy stuck high
    served.delete(); e0 = err_cnt;
    fu_d1 = 1; fu_r = RTO;
    a_i[7:0] = 8'd200; b_i[7:0] = 8'd3;
    req_i = 4'b0001;
    wait_served(1, 100);
    req_i = '0;
    chk("run_to_err", err_cnt - e0, 1);
    chk("run_to_y", y_o, 13'd792);

    // async reset during RUN, then a pending all-request restarts at pointer 0
    fu_d1 = 1; fu_r = 1000;
    req_i = 4'b0010;
    for (int i = 0; i < 20 && !fu_start_o; i++) tick();
    tick();
    chk("pre_rst_run", busy_o && !fu_start_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_gnt", gnt_o, 0);
    chk("arst_y", y_o, 0);
    chk("arst_fu_a", fu_a_o, 0);
    chk("arst_start", fu_start_o, 0);
    req_i = 4'b1111; fu_r = 2;
    tick(); tick();
    rst_n = 1'b1;
    wait_gnt(10);
    chk("post_rst_gnt", gnt_o, 4'b0001);
    served.delete();
    wait_served(1, 60);
    req_i = '0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (($urandom % 4) == 0) req_i = N'($urandom);
      a_i = $urandom;
      b_i = $urandom;
      test_req_i = (($urandom % 16) == 0);
      if (!busy_o && ($urandom % 4) == 0) begin
        fu_d1 = $urandom_range(1, ITO + 2);
        fu_r  = $urandom_range(0, RTO + 1);
      end
      tick();
    end
    req_i = '0; test_req_i = 1'b0;
    for (int i = 0; i < 60 && busy_o; i++) tick();
    tick();
    chk("final_idle", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/func_rr_scheduler.md
Name: func_rr_scheduler

Overview:
Time-shares one bist_logic function unit (FU) between NUM_REQ requesters.
- Arbitrates with a round-robin pointer.
- Drives the FU start/busy handshake and latches the 13-bit FU result.
- Returns the result to the winning requester with a one-cycle done pulse.
- Also forwards a self-test request that takes priority over all requesters.
- Sits between the user-side operand sources and the FU.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ISSUE_TO, 64, max cycles fu_start_o stays high waiting for fu_busy_i=1 before timeout
RUN_TO, 4096, max cycles waiting for fu_busy_i=0 after start drop before timeout

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
req_i  in  NUM_REQ  level request per requester, held until its done pulse
a_i  in  8*NUM_REQ  operand a, slice n belongs to requester n
b_i  in  8*NUM_REQ  operand b, slice n belongs to requester n
test_req_i  in  1  self-test request pulse, priority over req_i
gnt_o  out  NUM_REQ  one-hot grant, high from GRANT through DONE
done_o  out  NUM_REQ  one-cycle pulse to the granted requester in DONE
err_o  out  1  one-cycle pulse in DONE when the operation timed out
y_o  out  13  last captured FU result, held until next capture
busy_o  out  1  high in any state other than IDLE
fu_start_o  out  1  FU start
fu_test_o  out  1  FU test_button, one-cycle pulse
fu_a_o  out  8  registered operand a to FU
fu_b_o  out  8  registered operand b to FU
fu_busy_i  in  1  FU busy
fu_y_i  in  13  FU result

Behaviour:
- Reset (rst_i=0, async): state=IDLE, rr pointer=0, all outputs 0, y_o=0, fu_a_o=fu_b_o=0. Reset mid-operation aborts immediately; no done is issued.
- States: IDLE, GRANT, ISSUE, RUN, DONE, TEST.
- IDLE, test_req_i=1 (sampled there only): go to TEST. In TEST, fu_test_o=1 for 1 cycle, then state equals ISSUE with no requester granted (gnt_o=0, done_o=0).
- IDLE, any req_i set: pick the first set bit scanning from the rr pointer upward with wrap. Latch the winner index and its a/b slices into fu_a_o/fu_b_o. Go to GRANT.
- GRANT: 1 cycle, gnt_o one-hot asserted, operands stable. Then go to ISSUE.
- ISSUE: fu_start_o=1 and a cycle counter runs.
  - fu_busy_i=1: go to RUN and clear the counter.
  - Counter reaches ISSUE_TO: set the timeout flag and go to DONE.
- RUN: fu_start_o=0 and the counter runs.
  - fu_busy_i=0: capture fu_y_i into y_o and go to DONE.
  - Counter reaches RUN_TO: set the timeout flag and go to DONE; y_o is not updated.
- DONE: 1 cycle.
  - done_o[winner]=1 (requester ops only); err_o equals the timeout flag.
  - rr pointer <= (winner+1) mod NUM_REQ (requester ops only).
  - Clear the flag, drop gnt_o, go to IDLE.
- Minimum latency req_i to done_o: 1(IDLE) + 1(GRANT) + >=1(ISSUE) + >=1(RUN) + 1(DONE).
- Request changes:
  - req_i dropped mid-operation: the operation still completes and done still pulses.
  - req_i still high after done: it is a new request, subject to rotation.
  - Operand changes after GRANT are ignored.
- Simultaneous test_req_i and req_i in IDLE: the test wins; requesters wait.
- test_req_i outside IDLE is dropped.
- Wrap-around: pointer at NUM_REQ-1 with winner NUM_REQ-1 returns to 0.
- Single persistent requester is re-granted every pass.

Decomposition:
- Shared package: state encoding localparams, FU_Y_W=13, OP_W=8.
- Sub-module rr_pick: combinational round-robin priority pick. Inputs are req vector and pointer; outputs are one-hot winner and index.
- The timeout counter is inline, sized $clog2(max(ISSUE_TO,RUN_TO))+1.

Test Plan:
- Single request, bench instantiates bist_logic as FU: req_i=0001, a=12, b=60 → gnt_o=0001; done_o[0] pulses once; y_o[4:0]=3; err_o=0; busy_o low after DONE.
- All four request, slices (0,0),(1,1),(123,223),(255,255) → grant order 0,1,2,3; y_o[4:0] at each done = 0,1,11,16. A second all-request round starts at 0 (pointer wrapped).
- Fairness: req 0 and 2 held high continuously → grants alternate 0,2,0,2 with no starvation.
- Priority: test_req_i and req_i=0010 asserted in the same IDLE cycle → fu_test_o pulse, start/busy cycle with gnt_o=0, then requester 1 served. After settling on the test pass, y_o equals 13'b0001001010001.
- Timeouts: FU model never raises busy → err_o and done_o[0] pulse after ISSUE_TO cycles, y_o unchanged. FU busy stuck high → err_o after RUN_TO cycles.
- Async reset asserted during RUN → outputs go 0 immediately with no clock edge. After release, a pending request restarts from pointer 0.
